sipo_deserializer: RTL and testbench

Serial-in/parallel-out stage that sits directly downstream of the single-bit D flip-flop register. It consumes the registered bit stream (the flop's Q) one bit per qualified clock and assembles WIDTH-bit words. Completed words are presented through a one-deep holding register with a valid/ready handshake. Overrun is detected and reported as a sticky flag.

---
 rtl/sipo_pkg.sv | 17 +
 rtl/sipo_bit_counter.sv | 35 +++
 rtl/sipo_deserializer.sv | 96 +++++++++
 tb/tb_sipo_deserializer.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sipo_pkg.sv
// Shared types and helpers for the serial-in/parallel-out deserializer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package sipo_pkg;

   // Holding register occupancy
   typedef enum logic {
      HOLD_EMPTY = 1'b0,
      HOLD_FULL  = 1'b1
   } hold_state_t;

   // Width of a counter able to represent 0..width
   function automatic int cnt_width(input int width);
      return $clog2(width + 1);
   endfunction

endpackage

// File: rtl/sipo_bit_counter.sv
// Modulo-WIDTH bit counter; wrap flags the edge that samples the last bit of a word.
// Latency: count updates 1 cycle after an enabled edge; wrap is same-cycle (en && count==WIDTH-1).
// Backpressure: none, counts every enabled edge.
// Ports: clk, reset (sync, active-high), en (bit qualifier), count (bits so far), wrap (completing edge).
module sipo_bit_counter
   import sipo_pkg::*;
#(
   parameter int WIDTH = 8,
   localparam int CW   = cnt_width(WIDTH)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          en,
   output logic [CW-1:0] count,
   output logic          wrap
);

   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   // Internal decode only; feeds the parent's registers, never a top-level port
   assign wrap = en && (count == LAST);

   always_ff @(posedge clk) begin
      if (reset) begin
         count <= '0;
      end else if (en) begin
         if (count == LAST) begin
            count <= '0;
         end else begin
            count <= count + CW'(1);
         end
      end
   end

endmodule

// File: rtl/sipo_deserializer.sv
// Serial-in/parallel-out deserializer with a one-deep valid/ready holding register.
// Latency: word_valid rises 1 cycle after the edge sampling the word's final bit.
// Backpressure: none upstream; a word completing while the holder is full and not drained is dropped and sets sticky overrun.
// Ports: clk, reset (sync, active-high), din/din_valid (serial in), word_out/word_valid/word_ready (word out),
//        bit_count (partial-word progress), overrun/overrun_clr (sticky drop flag and its clear).
module sipo_deserializer
   import sipo_pkg::*;
#(
   parameter int WIDTH     = 8,
   parameter bit MSB_FIRST = 1'b1,
   localparam int CW       = cnt_width(WIDTH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             din,
   input  logic             din_valid,
   output logic [WIDTH-1:0] word_out,
   output logic             word_valid,
   input  logic             word_ready,
   output logic [CW-1:0]    bit_count,
   output logic             overrun,
   input  logic             overrun_clr
);

   logic [WIDTH-1:0] shreg;
   logic [WIDTH-1:0] shreg_next;
   logic             wrap;
   logic             drop;
   hold_state_t      state;

   sipo_bit_counter #(
      .WIDTH (WIDTH)
   ) u_cnt (
      .clk   (clk),
      .reset (reset),
      .en    (din_valid),
      .count (bit_count),
      .wrap  (wrap)
   );

   // The shifted value is also the completed word on the wrap edge,
   // so the holding register loads shreg_next directly.
   generate
      if (MSB_FIRST) begin : g_msb
         assign shreg_next = {shreg[WIDTH-2:0], din};
      end else begin : g_lsb
         assign shreg_next = {din, shreg[WIDTH-1:1]};
      end
   endgenerate

   // A completing word is lost only if the held word is not leaving this edge
   assign drop = (state == HOLD_FULL) && wrap && !word_ready;

   assign word_valid = (state == HOLD_FULL);

   always_ff @(posedge clk) begin
      if (reset) begin
         shreg    <= '0;
         word_out <= '0;
         overrun  <= 1'b0;
         state    <= HOLD_EMPTY;
      end else begin
         if (din_valid) begin
            shreg <= shreg_next;
         end

         case (state)
            HOLD_EMPTY: begin
               if (wrap) begin
                  word_out <= shreg_next;
                  state    <= HOLD_FULL;
               end
            end
            HOLD_FULL: begin
               if (wrap) begin
                  // Drain and refill on the same edge keeps the holder full
                  if (word_ready) begin
                     word_out <= shreg_next;
                  end
               end else if (word_ready) begin
                  state <= HOLD_EMPTY;
               end
            end
            default: state <= HOLD_EMPTY;
         endcase

         // Set beats clear when both happen on one edge
         if (drop) begin
            overrun <= 1'b1;
         end else if (overrun_clr) begin
            overrun <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_sipo_deserializer.sv
module tb_sipo_deserializer;

   logic       clk = 1'b0;
   logic       reset;
   logic       din;
   logic       din_valid;
   logic       word_ready;
   logic       overrun_clr;

   logic [7:0] m_word_out, l_word_out;
   logic       m_word_valid, l_word_valid;
   logic [3:0] m_bit_count, l_bit_count;
   logic       m_overrun, l_overrun;

   int total = 0;
   int bad   = 0;

   // Scoreboard: expected held words for each bit order
   logic [7:0] q_m[$];
   logic [7:0] q_l[$];
   bit         exp_full;
   bit         exp_ovr;

   always #5 clk = ~clk;

   sipo_deserializer #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_m (
      .clk(clk), .reset(reset), .din(din), .din_valid(din_valid),
      .word_out(m_word_out), .word_valid(m_word_valid), .word_ready(word_ready),
      .bit_count(m_bit_count), .overrun(m_overrun), .overrun_clr(overrun_clr)
   );

   sipo_deserializer #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_l (
      .clk(clk), .reset(reset), .din(din), .din_valid(din_valid),
      .word_out(l_word_out), .word_valid(l_word_valid), .word_ready(word_ready),
      .bit_count(l_bit_count), .overrun(l_overrun), .overrun_clr(overrun_clr)
   );

   function automatic logic [7:0] rev8(input logic [7:0] v);
      logic [7:0] r;
      for (int i = 0; i < 8; i++) r[i] = v[7-i];
      return r;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Sends v first-bit = v[7]; gap_mask[k] inserts an idle cycle after k bits.
   task automatic send_word(input logic [7:0] v, input logic [7:0] gap_mask,
                            input bit rdy_last, input bit clr_last);
      logic [3:0] exp_cnt;
      for (int i = 0; i < 8; i++) begin
         din       = v[7-i];
         din_valid = 1'b1;
         if (i == 7) begin
            word_ready  = rdy_last;
            overrun_clr = clr_last;
            if (exp_full && rdy_last) begin
               void'(q_m.pop_front());
               void'(q_l.pop_front());
            end
            if (!exp_full || rdy_last) begin
               q_m.push_back(v);
               q_l.push_back(rev8(v));
            end else begin
               exp_ovr = 1'b1;
            end
            if (clr_last && !(exp_full && !rdy_last)) exp_ovr = 1'b0;
            exp_full = 1'b1;
         end
         step();
         din_valid   = 1'b0;
         word_ready  = 1'b0;
         overrun_clr = 1'b0;
         exp_cnt = 4'((i + 1) % 8);
         total++;
         if (m_bit_count !== exp_cnt || l_bit_count !== exp_cnt)
            $display("FAIL bit_count after bit %0d: got %0d/%0d want %0d", i + 1, m_bit_count, l_bit_count, exp_cnt);
         if (m_bit_count !== exp_cnt || l_bit_count !== exp_cnt) bad++;
         if (i < 7 && gap_mask[i+1]) begin
            step();
            total++;
            if (m_bit_count !== exp_cnt || l_bit_count !== exp_cnt) begin
               bad++;
               $display("FAIL bit_count gap after %0d: got %0d/%0d want %0d", i + 1, m_bit_count, l_bit_count, exp_cnt);
            end
         end
      end
   endtask

   task automatic check_held(input string name);
      total++;
      if (m_word_valid !== 1'b1 || l_word_valid !== 1'b1) begin
         bad++;
         $display("FAIL %s word_valid: got %b/%b want 1", name, m_word_valid, l_word_valid);
      end
      total++;
      if (q_m.size() == 0) begin
         bad++;
         $display("FAIL %s scoreboard empty: got word %h want a queued word", name, m_word_out);
      end else if (m_word_out !== q_m[0] || l_word_out !== q_l[0]) begin
         bad++;
         $display("FAIL %s word_out: got %h/%h want %h/%h", name, m_word_out, l_word_out, q_m[0], q_l[0]);
      end
   endtask

   task automatic consume(input string name);
      logic [7:0] em, el;
      em = (q_m.size() != 0) ? q_m.pop_front() : 8'h00;
      el = (q_l.size() != 0) ? q_l.pop_front() : 8'h00;
      word_ready = 1'b1;
      step();
      word_ready = 1'b0;
      exp_full   = 1'b0;
      total++;
      if (m_word_valid !== 1'b0 || l_word_valid !== 1'b0) begin
         bad++;
         $display("FAIL %s drain word_valid: got %b/%b want 0", name, m_word_valid, l_word_valid);
      end
      total++;
      if (m_word_out !== em || l_word_out !== el) begin
         bad++;
         $display("FAIL %s drain word_out hold: got %h/%h want %h/%h", name, m_word_out, l_word_out, em, el);
      end
   endtask

   task automatic check_ovr(input string name);
      total++;
      if (m_overrun !== exp_ovr || l_overrun !== exp_ovr) begin
         bad++;
         $display("FAIL %s overrun: got %b/%b want %b", name, m_overrun, l_overrun, exp_ovr);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1; din = 1'b0; din_valid = 1'b0; word_ready = 1'b0; overrun_clr = 1'b0;
      step();
      step();
      reset = 1'b0;
      exp_full = 1'b0; exp_ovr = 1'b0;
      q_m.delete(); q_l.delete();
      total++;
      if (m_word_valid !== 1'b0 || m_bit_count !== 4'd0 || m_overrun !== 1'b0 || m_word_out !== 8'h00 ||
          l_word_valid !== 1'b0 || l_bit_count !== 4'd0 || l_overrun !== 1'b0 || l_word_out !== 8'h00) begin
         bad++;
         $display("FAIL reset state: got v=%b cnt=%0d ovr=%b out=%h want 0/0/0/00",
                  m_word_valid, m_bit_count, m_overrun, m_word_out);
      end
   endtask

   task automatic test_basic();
      send_word(8'hB1, 8'h00, 1'b0, 1'b0);
      check_held("basic");
      // Explicit constants as well as the scoreboard for the headline case
      total++;
      if (m_word_out !== 8'hB1 || l_word_out !== 8'h8D) begin
         bad++;
         $display("FAIL basic const: got %h/%h want b1/8d", m_word_out, l_word_out);
      end
      // Holder stable while not drained
      step();
      step();
      check_held("basic_stall");
      consume("basic");
      // Ready while empty is ignored
      word_ready = 1'b1;
      step();
      word_ready = 1'b0;
      total++;
      if (m_word_valid !== 1'b0) begin
         bad++;
         $display("FAIL empty_ready word_valid: got %b want 0", m_word_valid);
      end
   endtask

   task automatic test_gaps();
      send_word(8'hB1, 8'b0100_1000, 1'b0, 1'b0);
      check_held("gaps");
      consume("gaps");
   endtask

   task automatic test_overrun();
      send_word(8'hB1, 8'h00, 1'b0, 1'b0);
      send_word(8'h3C, 8'h00, 1'b0, 1'b0);
      check_held("overrun_hold");
      check_ovr("overrun_set");
      step();
      check_ovr("overrun_sticky");
      overrun_clr = 1'b1;
      step();
      overrun_clr = 1'b0;
      exp_ovr = 1'b0;
      check_ovr("overrun_clr");
      check_held("overrun_after_clr");
      consume("overrun");
   endtask

   task automatic test_back_to_back();
      send_word(8'hB1, 8'h00, 1'b0, 1'b0);
      send_word(8'h3C, 8'h00, 1'b1, 1'b0);
      check_held("b2b");
      check_ovr("b2b");
      consume("b2b");
   endtask

   task automatic test_set_wins();
      send_word(8'hA5, 8'h00, 1'b0, 1'b0);
      send_word(8'h0F, 8'h00, 1'b0, 1'b1);
      check_ovr("set_wins");
      check_held("set_wins");
      overrun_clr = 1'b1;
      step();
      overrun_clr = 1'b0;
      exp_ovr = 1'b0;
      check_ovr("set_wins_clr");
      consume("set_wins");
   endtask

   task automatic test_reset_mid();
      logic [7:0] junk;
      send_word(8'hC3, 8'h00, 1'b0, 1'b0);
      junk = 8'hFF;
      for (int i = 0; i < 5; i++) begin
         din = junk[7-i]; din_valid = 1'b1;
         step();
      end
      din_valid = 1'b0;
      reset = 1'b1;
      step();
      reset = 1'b0;
      q_m.delete(); q_l.delete();
      exp_full = 1'b0; exp_ovr = 1'b0;
      total++;
      if (m_bit_count !== 4'd0 || m_word_valid !== 1'b0 || m_overrun !== 1'b0 ||
          l_bit_count !== 4'd0 || l_word_valid !== 1'b0 || l_overrun !== 1'b0) begin
         bad++;
         $display("FAIL reset_mid state: got cnt=%0d v=%b ovr=%b want 0/0/0", m_bit_count, m_word_valid, m_overrun);
      end
      send_word(8'h5A, 8'h00, 1'b0, 1'b0);
      check_held("reset_mid");
      consume("reset_mid");
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_basic();
      test_gaps();
      test_overrun();
      test_back_to_back();
      test_set_wins();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
